return_addr_stack: RTL



---
 rtl/proc_pkg.sv | 24 ++
 rtl/ras_regfile.sv | 28 ++
 rtl/return_addr_stack.sv | 139 +++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared processor constants and helpers used by the fetch-side blocks.
package proc_pkg;

    localparam int PC_W      = 12;  // program-counter width
    localparam int OFS_W     = 8;   // signed relative-branch offset width
    localparam int RAS_DEPTH = 8;   // return-address stack entries

    // Decoded stack operation for one cycle.
    typedef enum logic [1:0] {
        RAS_HOLD    = 2'b00,
        RAS_PUSH    = 2'b01,
        RAS_POP     = 2'b10,
        RAS_REPLACE = 2'b11
    } ras_op_e;

    // True when a PC_W-bit two's-complement value survives truncation to
    // 'width' bits, i.e. bits [PC_W-1:width-1] are all copies of the sign.
    function automatic logic fits_signed(input logic [PC_W-1:0] value, input int width);
        logic [PC_W-1:0] hi;
        hi = $signed(value) >>> (width - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/ras_regfile.sv
// DEPTH x T entry storage: one synchronous write port, one combinational read.
module ras_regfile
    import proc_pkg::*;
#(
    parameter int T     = PC_W,
    parameter int DEPTH = RAS_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [T-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [T-1:0]  rdata
);

    logic [T-1:0] mem [DEPTH];

    // Entry write; contents are intentionally never reset.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Call/return stack feeding the fetch stage's relative-branch Target input.
//
// Command semantics: Push and Pop are single-cycle commands with no
// handshake; each is sampled on every posedge and is always accepted.
// A Push while Full or a Pop while Empty is dropped and recorded in the
// sticky Overflow/Underflow flags instead of back-pressuring the caller.
module return_addr_stack
    import proc_pkg::*;
#(
    parameter int T     = PC_W,
    parameter int DEPTH = RAS_DEPTH,
    parameter int OFS_W = proc_pkg::OFS_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Push,
    input  logic          Pop,
    input  logic [T-1:0]  ProgCtr,
    output logic [T-1:0]  Target,
    output logic [T-1:0]  TopAddr,
    output logic [CW-1:0] Count,
    output logic          Empty,
    output logic          Full,
    output logic          Overflow,
    output logic          Underflow,
    output logic          RangeErr
);

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [CW-1:0] count_m1;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] waddr;
    logic          we;
    logic [T-1:0]  top_rd;
    logic [T-1:0]  ret_addr;
    ras_op_e       op;

    assign count_m1 = count_q - 1'b1;
    assign top_idx  = count_m1[AW-1:0];
    assign ret_addr = ProgCtr + 1'b1;
    assign Empty    = (count_q == '0);
    assign Full     = (count_q == CW'(DEPTH));

    ras_regfile #(
        .T     (T),
        .DEPTH (DEPTH)
    ) u_regfile (
        .Clk   (Clk),
        .we    (we & ~Reset & ~Start),
        .waddr (waddr),
        .wdata (ret_addr),
        .raddr (top_idx),
        .rdata (top_rd)
    );

    // Decode the two command lines into one operation.
    always_comb begin
        op = RAS_HOLD;
        case ({Pop, Push})
            2'b01:   op = RAS_PUSH;
            2'b10:   op = RAS_POP;
            2'b11:   op = RAS_REPLACE;
            default: op = RAS_HOLD;
        endcase
    end

    // Next count, flag updates and entry write for the decoded operation.
    always_comb begin
        we      = 1'b0;
        waddr   = count_q[AW-1:0];
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (op)
            RAS_PUSH: begin
                if (Full) begin
                    ovf_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            RAS_POP: begin
                if (Empty) begin
                    unf_d = 1'b1;
                end else begin
                    count_d = count_m1;
                end
            end
            RAS_REPLACE: begin
                // Return immediately followed by a call: overwrite the top.
                // On an empty stack the pop part fails and the push proceeds.
                we = 1'b1;
                if (Empty) begin
                    unf_d   = 1'b1;
                    count_d = CW'(1);
                end else begin
                    waddr = top_idx;
                end
            end
            default: begin
            end
        endcase
    end

    // Pointer and sticky flags; Start clears exactly like Reset.
    always_ff @(posedge Clk) begin
        if (Reset || Start) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Zero-latency return offset: fetch adds it to ProgCtr on the pop edge.
    always_comb begin
        Target   = '0;
        RangeErr = 1'b0;
        if (Pop && !Empty) begin
            Target   = top_rd - ProgCtr;
            RangeErr = ~fits_signed(Target, OFS_W);
        end
    end

    assign TopAddr   = Empty ? '0 : top_rd;
    assign Count     = count_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule
